// File: rtl/mandel_raster_engine.sv
// mandel_raster_engine: walks a cols x rows raster of Mandelbrot pixels in row-major order,
// iterating z <= z^2 + c at one step per clock and streaming one result per pixel.
// Ports: clk, rst (sync, active-low); start/abort job control; cr0/ci0 origin, dcr/dci steps,
// cols/rows size, max_iter cap; busy/done status; out_valid/out_ready result stream carrying
// out_x/out_y pixel, out_iter count, out_escaped flag and final z (out_zr/out_zi).
module mandel_raster_engine #(
    parameter int W      = 27,
    parameter int FRAC   = 23,
    parameter int ITER_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [W-1:0]      cr0,
    input  logic [W-1:0]      ci0,
    input  logic [W-1:0]      dcr,
    input  logic [W-1:0]      dci,
    input  logic [DIM_W-1:0]  cols,
    input  logic [DIM_W-1:0]  rows,
    input  logic [ITER_W-1:0] max_iter,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM_W-1:0]  out_x,
    output logic [DIM_W-1:0]  out_y,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic [W-1:0]      out_zr,
    output logic [W-1:0]      out_zi
);
    localparam int P = 2 * W;
    localparam logic signed [W-1:0] TWO = {{(W-FRAC-2){1'b0}}, 2'b10, {FRAC{1'b0}}};
    localparam logic [W:0] FOUR = {{(W-FRAC-2){1'b0}}, 3'b100, {FRAC{1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, ITER, OUT, FIN} state_t;
    state_t state, state_n;

    logic signed [W-1:0] cr0_q, dcr_q, dci_q, cr, ci, zr, zi;
    logic [DIM_W-1:0] cols_q, rows_q, x, y;
    logic [ITER_W-1:0] max_q, n;
    logic esc;
    logic signed [W-1:0] rr, ii, ri2;
    logic [W:0] mag;
    logic hit, big, escape, row_end, last;

    // Full-width products, arithmetic shift (floor), keep low W bits.
    // 2*zr*zi folds the doubling into the shift to keep one more bit of precision.
    assign rr  = W'((P'(zr) * P'(zr)) >>> FRAC);
    assign ii  = W'((P'(zi) * P'(zi)) >>> FRAC);
    assign ri2 = W'((P'(zr) * P'(zi)) >>> (FRAC - 1));
    assign mag = {rr[W-1], rr} + {ii[W-1], ii};

    assign hit     = n == max_q;
    // The |z|>=2 guard runs before the squares are trusted, so they never overflow.
    assign big     = (zr >= TWO) || (zr <= -TWO) || (zi >= TWO) || (zi <= -TWO);
    assign escape  = big || (mag > FOUR);
    assign row_end = x == cols_q - DIM_W'(1);
    assign last    = row_end && (y == rows_q - DIM_W'(1));

    assign busy        = (state == LOAD) || (state == ITER) || (state == OUT);
    assign done        = state == FIN;
    assign out_valid   = state == OUT;
    assign out_x       = x;
    assign out_y       = y;
    assign out_iter    = n;
    assign out_escaped = esc;
    assign out_zr      = zr;
    assign out_zi      = zi;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (cols == '0 || rows == '0) ? FIN : LOAD;
            LOAD:    state_n = ITER;
            ITER:    if (hit || escape) state_n = OUT;
            OUT:     if (out_ready) state_n = last ? FIN : LOAD;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cr0_q  <= '0;
            dcr_q  <= '0;
            dci_q  <= '0;
            cols_q <= '0;
            rows_q <= '0;
            max_q  <= '0;
            cr     <= '0;
            ci     <= '0;
            x      <= '0;
            y      <= '0;
            zr     <= '0;
            zi     <= '0;
            n      <= '0;
            esc    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                cr0_q  <= cr0;
                dcr_q  <= dcr;
                dci_q  <= dci;
                cols_q <= cols;
                rows_q <= rows;
                max_q  <= max_iter;
                cr     <= cr0;
                ci     <= ci0;
                x      <= '0;
                y      <= '0;
            end
            if (state == LOAD) begin
                zr  <= '0;
                zi  <= '0;
                n   <= '0;
                esc <= 1'b0;
            end
            if (state == ITER && !hit) begin
                if (escape) begin
                    esc <= 1'b1;
                end else begin
                    zr <= rr - ii + cr;
                    zi <= ri2 + ci;
                    n  <= n + ITER_W'(1);
                end
            end
            // Coordinates are accumulated rather than multiplied out.
            if (state == OUT && out_ready && !abort && !last) begin
                if (row_end) begin
                    x  <= '0;
                    cr <= cr0_q;
                    y  <= y + DIM_W'(1);
                    ci <= ci + dci_q;
                end else begin
                    x  <= x + DIM_W'(1);
                    cr <= cr + dcr_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_mandel_raster_engine.sv
// tb_mandel_raster_engine: directed self-checking bench for mandel_raster_engine.
module tb_mandel_raster_engine;
    localparam int W = 27;
    localparam int FRAC = 23;
    localparam int ITER_W = 16;
    localparam int DIM_W = 10;
    localparam int SW = 2 * DIM_W + ITER_W + 1 + 2 * W;

    localparam logic [W-1:0] NEG_ONE = 27'h7800000;
    localparam logic [W-1:0] HALF    = 27'h0400000;
    localparam logic [W-1:0] ONE     = 27'h0800000;
    localparam logic [W-1:0] ONE_P5  = 27'h0C00000;
    localparam logic [W-1:0] TWO     = 27'h1000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [W-1:0] cr0 = '0, ci0 = '0, dcr = '0, dci = '0;
    logic [DIM_W-1:0] cols = '0, rows = '0;
    logic [ITER_W-1:0] max_iter = '0;
    logic busy, done, out_valid, out_escaped;
    logic out_ready = 1'b0;
    logic [DIM_W-1:0] out_x, out_y;
    logic [ITER_W-1:0] out_iter;
    logic [W-1:0] out_zr, out_zi;

    int checks = 0;
    int errors = 0;

    logic [DIM_W-1:0] rx [8];
    logic [DIM_W-1:0] ry [8];
    logic [ITER_W-1:0] riter [8];
    logic resc [8];
    logic [W-1:0] rzr [8];
    logic [W-1:0] rzi [8];
    int nres, lat, done_cnt, done_gap;
    logic stall_ok, timed_out;

    always #5 clk = ~clk;

    mandel_raster_engine #(.W(W), .FRAC(FRAC), .ITER_W(ITER_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cr0(cr0), .ci0(ci0), .dcr(dcr), .dci(dci),
        .cols(cols), .rows(rows), .max_iter(max_iter),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_iter(out_iter), .out_escaped(out_escaped),
        .out_zr(out_zr), .out_zi(out_zi)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_job(input logic [W-1:0] a_cr0, input logic [W-1:0] a_ci0,
                           input logic [W-1:0] a_dcr, input logic [W-1:0] a_dci,
                           input logic [DIM_W-1:0] a_cols, input logic [DIM_W-1:0] a_rows,
                           input logic [ITER_W-1:0] a_max);
        cr0 = a_cr0;
        ci0 = a_ci0;
        dcr = a_dcr;
        dci = a_dci;
        cols = a_cols;
        rows = a_rows;
        max_iter = a_max;
    endtask

    // Starts a job (optionally with abort alongside start), accepts every result and records it.
    // Latency counts clock edges from the start edge to the first out_valid.
    task automatic run_job(input int hold_idx, input logic with_abort);
        int cyc, last_hs;
        logic [SW-1:0] snap;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc = 1;
        last_hs = 0;
        nres = 0;
        lat = -1;
        done_cnt = 0;
        done_gap = -1;
        stall_ok = 1'b1;
        timed_out = 1'b1;
        while (cyc < 3000) begin
            if (done) begin
                done_cnt++;
                done_gap = cyc - last_hs;
                timed_out = 1'b0;
                break;
            end
            if (out_valid) begin
                if (lat < 0) lat = cyc;
                if (nres < 8) begin
                    rx[nres] = out_x;
                    ry[nres] = out_y;
                    riter[nres] = out_iter;
                    resc[nres] = out_escaped;
                    rzr[nres] = out_zr;
                    rzi[nres] = out_zi;
                end
                if (nres == hold_idx) begin
                    snap = {out_x, out_y, out_iter, out_escaped, out_zr, out_zi};
                    repeat (5) begin
                        @(negedge clk);
                        cyc++;
                        if (!out_valid || {out_x, out_y, out_iter, out_escaped, out_zr, out_zi} != snap)
                            stall_ok = 1'b0;
                    end
                end
                out_ready = 1'b1;
                last_hs = cyc;
                @(negedge clk);
                out_ready = 1'b0;
                cyc++;
                nres++;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if ({out_x, out_y, out_iter, out_escaped, out_zr, out_zi} !== '0) begin
            errors++;
            $display("FAIL reset_data: got x=%h y=%h it=%h e=%b zr=%h zi=%h expected all 0",
                     out_x, out_y, out_iter, out_escaped, out_zr, out_zi);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_origin;
        set_job('0, '0, '0, '0, 10'd1, 10'd1, 16'd10);
        run_job(-1, 1'b1);
        checks++;
        if (nres !== 1 || timed_out) begin errors++; $display("FAIL origin_count: got %0d to=%b expected 1", nres, timed_out); end
        checks++;
        if ({rx[0], ry[0]} !== '0) begin errors++; $display("FAIL origin_xy: got %0d,%0d expected 0,0", rx[0], ry[0]); end
        checks++;
        if (riter[0] !== 16'd10 || resc[0] !== 1'b0) begin
            errors++;
            $display("FAIL origin_iter: got %0d esc=%b expected 10 esc=0", riter[0], resc[0]);
        end
        checks++;
        if (rzr[0] !== '0 || rzi[0] !== '0) begin errors++; $display("FAIL origin_z: got %h %h expected 0 0", rzr[0], rzi[0]); end
        checks++;
        if (lat !== 13) begin errors++; $display("FAIL origin_latency: got %0d expected 13", lat); end
        checks++;
        if (done_gap !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL origin_done: got gap=%0d count=%0d expected gap=1 count=1", done_gap, done_cnt);
        end
    endtask

    task automatic test_guard;
        set_job(ONE, '0, '0, '0, 10'd1, 10'd1, 16'd50);
        run_job(-1, 1'b0);
        checks++;
        if (riter[0] !== 16'd2 || resc[0] !== 1'b1) begin
            errors++;
            $display("FAIL guard_iter: got %0d esc=%b expected 2 esc=1", riter[0], resc[0]);
        end
        checks++;
        if (rzr[0] !== TWO || rzi[0] !== '0) begin errors++; $display("FAIL guard_z: got %h %h expected %h 0", rzr[0], rzi[0], TWO); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL guard_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_magnitude;
        set_job(ONE_P5, ONE_P5, '0, '0, 10'd1, 10'd1, 16'd50);
        run_job(-1, 1'b0);
        checks++;
        if (riter[0] !== 16'd1 || resc[0] !== 1'b1) begin
            errors++;
            $display("FAIL mag_iter: got %0d esc=%b expected 1 esc=1", riter[0], resc[0]);
        end
        checks++;
        if (rzr[0] !== ONE_P5 || rzi[0] !== ONE_P5) begin
            errors++;
            $display("FAIL mag_z: got %h %h expected %h %h", rzr[0], rzi[0], ONE_P5, ONE_P5);
        end
    endtask

    task automatic check_raster(input string tag);
        checks++;
        if (nres !== 6 || timed_out) begin errors++; $display("FAIL %s_count: got %0d to=%b expected 6", tag, nres, timed_out); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx[i] !== DIM_W'(i % 3) || ry[i] !== DIM_W'(i / 3)) begin
                errors++;
                $display("FAIL %s_order%0d: got %0d,%0d expected %0d,%0d", tag, i, rx[i], ry[i], i % 3, i / 3);
            end
        end
        checks++;
        if (riter[0] !== 16'd20 || resc[0] !== 1'b0 || rzr[0] !== '0 || rzi[0] !== '0) begin
            errors++;
            $display("FAIL %s_p0: got it=%0d e=%b zr=%h zi=%h expected 20 0 0 0", tag, riter[0], resc[0], rzr[0], rzi[0]);
        end
        checks++;
        if (riter[1] !== 16'd20 || resc[1] !== 1'b0) begin
            errors++;
            $display("FAIL %s_p1: got it=%0d e=%b expected 20 0", tag, riter[1], resc[1]);
        end
        checks++;
        if (riter[2] !== 16'd20 || resc[2] !== 1'b0 || rzr[2] !== '0 || rzi[2] !== '0) begin
            errors++;
            $display("FAIL %s_p2: got it=%0d e=%b zr=%h zi=%h expected 20 0 0 0", tag, riter[2], resc[2], rzr[2], rzi[2]);
        end
        checks++;
        if (riter[3] !== 16'd5 || resc[3] !== 1'b1 || rzr[3] !== 27'h6B0D880 || rzi[3] !== 27'h071F800) begin
            errors++;
            $display("FAIL %s_p3: got it=%0d e=%b zr=%h zi=%h expected 5 1 6b0d880 071f800", tag, riter[3], resc[3], rzr[3], rzi[3]);
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s_done: got %0d expected 1", tag, done_cnt); end
    endtask

    task automatic test_raster;
        set_job(NEG_ONE, '0, HALF, HALF, 10'd3, 10'd2, 16'd20);
        run_job(2, 1'b0);
        check_raster("raster");
        checks++;
        if (stall_ok !== 1'b1) begin errors++; $display("FAIL raster_stall: got %b expected 1", stall_ok); end
    endtask

    task automatic test_max_zero;
        set_job(ONE_P5, ONE_P5, HALF, '0, 10'd2, 10'd1, 16'd0);
        run_job(-1, 1'b0);
        checks++;
        if (nres !== 2) begin errors++; $display("FAIL max0_count: got %0d expected 2", nres); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (riter[i] !== '0 || resc[i] !== 1'b0 || rzr[i] !== '0 || rzi[i] !== '0) begin
                errors++;
                $display("FAIL max0_p%0d: got it=%0d e=%b zr=%h zi=%h expected all 0", i, riter[i], resc[i], rzr[i], rzi[i]);
            end
        end
    endtask

    task automatic test_zero_size;
        logic seen;
        set_job('0, '0, '0, '0, 10'd0, 10'd4, 16'd10);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b valid=%b expected 1 0", done, out_valid);
        end
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if (done || busy || out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL zero_restart_ignored: got activity=%b expected 0", seen); end
    endtask

    task automatic start_raster;
        set_job(NEG_ONE, '0, HALF, HALF, 10'd3, 10'd2, 16'd20);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_abort;
        logic seen;
        start_raster();
        for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_first_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, out_valid} !== 2'b10 || out_x !== 10'd1) begin
            errors++;
            $display("FAIL abort_in_iter: got busy=%b valid=%b x=%0d expected 1 0 1", busy, out_valid, out_x);
        end
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b done=%b valid=%b expected 0 0 0", busy, done, out_valid);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet: got activity=%b expected 0", seen); end
    endtask

    task automatic test_reset_mid_out;
        start_raster();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
            if (r < 4) begin
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_x !== 10'd1 || out_y !== 10'd1) begin
            errors++;
            $display("FAIL rstout_pre: got valid=%b x=%0d y=%0d expected 1 1 1", out_valid, out_x, out_y);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, out_valid, out_x, out_y, out_iter, out_escaped, out_zr, out_zi} !== '0) begin
            errors++;
            $display("FAIL rstout_zero: got b=%b d=%b v=%b x=%h y=%h it=%h e=%b zr=%h zi=%h expected all 0",
                     busy, done, out_valid, out_x, out_y, out_iter, out_escaped, out_zr, out_zi);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_restart;
        set_job(NEG_ONE, '0, HALF, HALF, 10'd3, 10'd2, 16'd20);
        run_job(-1, 1'b0);
        check_raster("restart");
    endtask

    initial begin
        test_reset();
        test_origin();
        test_guard();
        test_magnitude();
        test_raster();
        test_max_zero();
        test_zero_size();
        test_abort();
        test_reset_mid_out();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
